// File: rtl/pcihellocore_pio_poller_if.sv
// Bus bundle for the PIO poller: host-side register port, shared PIO master port and irq.
// The slave modport is the poller's view; master is the host/PIO environment around it.
interface pcihellocore_pio_poller_if #(
    parameter int NUM_PORTS = 4
);
    logic [2:0]           s_address;
    logic                 s_chipselect;
    logic                 s_read;
    logic                 s_write_n;
    logic [31:0]          s_writedata;
    logic [31:0]          s_readdata;
    logic [NUM_PORTS-1:0] m_select;
    logic [1:0]           m_address;
    logic                 m_chipselect;
    logic                 m_write_n;
    logic [31:0]          m_writedata;
    logic [31:0]          m_readdata;
    logic                 irq;

    modport slave (
        input  s_address, s_chipselect, s_read, s_write_n, s_writedata, m_readdata,
        output s_readdata, m_select, m_address, m_chipselect, m_write_n, m_writedata, irq
    );

    modport master (
        output s_address, s_chipselect, s_read, s_write_n, s_writedata, m_readdata,
        input  s_readdata, m_select, m_address, m_chipselect, m_write_n, m_writedata, irq
    );
endinterface

// File: rtl/pcihellocore_pio_poller.sv
// Round-robin PIO poller with change-event FIFO and forwarded-write arbitration.
// Optional PIO_POLL_TIMESTAMP_EN adds a free-running cycle counter and per-event timestamps.
module pcihellocore_pio_poller #(
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    pcihellocore_pio_poller_if.slave    bus
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, UPDATE} state_t;

    state_t               state;
    logic                 enable;
    logic                 irq_en;
    logic [15:0]          interval;
    logic [15:0]          tick_cnt;
    logic                 poll_req;
    logic                 overflow;
    logic                 wr_drop;
    logic                 wr_busy;
    logic [PW-1:0]        out_sel;
    logic [PW-1:0]        wr_target;
    logic [31:0]          wr_data;
    logic [PW-1:0]        rr;
    logic [31:0]          rd_cap;
    logic [31:0]          shadow [NUM_PORTS];
    logic [NUM_PORTS-1:0] primed;
    logic [31:0]          fifo_data [FIFO_DEPTH];
    logic [PW-1:0]        fifo_port [FIFO_DEPTH];
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic [CW-1:0]        count;
    logic [31:0]          rd_mux;
    logic [31:0]          status;

`ifdef PIO_POLL_TIMESTAMP_EN
    logic [31:0]          tstamp;
    logic [31:0]          fifo_time [FIFO_DEPTH];
`endif

    logic host_rd, host_wr, pop, fifo_full, event_hit, push;

    assign host_rd   = bus.s_chipselect & bus.s_read;
    assign host_wr   = bus.s_chipselect & ~bus.s_write_n;
    assign pop       = host_rd && (bus.s_address == 3'd3) && (count != '0);
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign event_hit = (state == UPDATE) && primed[rr] && (rd_cap != shadow[rr]);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = event_hit && (!fifo_full || pop);

    assign bus.m_address = 2'b00;

    function automatic logic [NUM_PORTS-1:0] onehot(input logic [PW-1:0] idx);
        logic [NUM_PORTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            enable           <= 1'b0;
            irq_en           <= 1'b0;
            interval         <= '0;
            tick_cnt         <= '0;
            poll_req         <= 1'b0;
            overflow         <= 1'b0;
            wr_drop          <= 1'b0;
            wr_busy          <= 1'b0;
            out_sel          <= '0;
            wr_target        <= '0;
            rr               <= '0;
            primed           <= '0;
            wptr             <= '0;
            rptr             <= '0;
            count            <= '0;
            bus.m_select     <= '0;
            bus.m_chipselect <= 1'b0;
            bus.m_write_n    <= 1'b1;
            bus.m_writedata  <= '0;
            bus.irq          <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) shadow[i] <= '0;
        end else begin
            if (host_wr && bus.s_address == 3'd0) begin
                enable   <= bus.s_writedata[0];
                irq_en   <= bus.s_writedata[1];
                interval <= bus.s_writedata[31:16];
            end
            if (host_wr && bus.s_address == 3'd4)
                out_sel <= PW'(32'(bus.s_writedata[3:0]) % NUM_PORTS);
            if (host_wr && bus.s_address == 3'd5) begin
                if (wr_busy) begin
                    wr_drop <= 1'b1;
                end else begin
                    wr_busy   <= 1'b1;
                    wr_target <= out_sel;
                end
            end
            if (host_wr && bus.s_address == 3'd1) begin
                if (bus.s_writedata[0]) overflow <= 1'b0;
                if (bus.s_writedata[1]) wr_drop  <= 1'b0;
            end
            if (event_hit && fifo_full && !pop) overflow <= 1'b1;

            // Interval 0 reloads to 0, so it ticks every cycle like interval 1.
            if (!enable)
                tick_cnt <= '0;
            else if (tick_cnt == '0)
                tick_cnt <= (interval == '0) ? '0 : interval - 16'd1;
            else
                tick_cnt <= tick_cnt - 16'd1;

            if (!enable)
                poll_req <= 1'b0;
            else if (tick_cnt == '0)
                poll_req <= 1'b1;
            else if (state == RD_ADDR)
                poll_req <= 1'b0;

            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);

            if (!enable) primed <= '0;

            case (state)
                IDLE: begin
                    if (wr_busy) begin
                        state            <= WRITE;
                        bus.m_select     <= onehot(wr_target);
                        bus.m_chipselect <= 1'b1;
                        bus.m_write_n    <= 1'b0;
                        bus.m_writedata  <= wr_data;
                    end else if (poll_req && enable) begin
                        state            <= RD_ADDR;
                        bus.m_select     <= onehot(rr);
                        bus.m_chipselect <= 1'b1;
                        bus.m_write_n    <= 1'b1;
                    end
                end
                WRITE: begin
                    state            <= IDLE;
                    wr_busy          <= 1'b0;
                    bus.m_select     <= '0;
                    bus.m_chipselect <= 1'b0;
                    bus.m_write_n    <= 1'b1;
                end
                RD_ADDR: state <= RD_WAIT;
                RD_WAIT: begin
                    state            <= UPDATE;
                    bus.m_select     <= '0;
                    bus.m_chipselect <= 1'b0;
                end
                UPDATE: begin
                    state      <= IDLE;
                    primed[rr] <= 1'b1;
                    shadow[rr] <= rd_cap;
                    rr         <= (rr == PW'(NUM_PORTS - 1)) ? '0 : rr + 1'b1;
                end
                default: state <= IDLE;
            endcase

            bus.irq <= irq_en & ((count != '0) | overflow);
        end
    end

    // Data-only storage: contents are meaningless until qualified by state or count.
    always_ff @(posedge clk) begin
        if (state == RD_WAIT) rd_cap <= bus.m_readdata;
        if (host_wr && bus.s_address == 3'd5 && !wr_busy) wr_data <= bus.s_writedata;
        if (push) begin
            fifo_data[wptr] <= rd_cap;
            fifo_port[wptr] <= rr;
`ifdef PIO_POLL_TIMESTAMP_EN
            fifo_time[wptr] <= tstamp;
`endif
        end
    end

`ifdef PIO_POLL_TIMESTAMP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tstamp <= '0;
        else          tstamp <= tstamp + 32'd1;
    end
`endif

    always_comb begin
        status         = '0;
        status[20:16]  = 5'(count);
        status[8]      = wr_busy;
        status[1]      = wr_drop;
        status[0]      = overflow;
        rd_mux         = '0;
        case (bus.s_address)
            3'd0: rd_mux = {interval, 14'd0, irq_en, enable};
            3'd1: rd_mux = status;
            3'd2: rd_mux = (count != '0) ? {1'b1, 27'd0, 4'(fifo_port[rptr])} : 32'd0;
            3'd3: rd_mux = (count != '0) ? fifo_data[rptr] : 32'd0;
            3'd4: rd_mux = {28'd0, 4'(out_sel)};
`ifdef PIO_POLL_TIMESTAMP_EN
            3'd6: rd_mux = (count != '0) ? fifo_time[rptr] : 32'd0;
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.s_readdata <= '0;
        else          bus.s_readdata <= rd_mux;
    end
endmodule

// File: tb/tb_pcihellocore_pio_poller.sv
// Directed bench for pcihellocore_pio_poller: four PIO ports modelled as a mux of pio_in[].
module tb_pcihellocore_pio_poller;
    logic        clk;
    logic        reset_n;
    logic [31:0] pio_in [4];
    logic [31:0] rd;
    logic [31:0] t1, t2;
    int          cyc = 0;
    int          ta, tb;
    int          total = 0;
    int          passed = 0;
    int          failed = 0;
    logic [31:0] drain_exp [8];

    pcihellocore_pio_poller_if #(.NUM_PORTS(4)) bus ();

    pcihellocore_pio_poller #(.NUM_PORTS(4), .FIFO_DEPTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        bus.m_readdata = '0;
        for (int i = 0; i < 4; i++)
            if (bus.m_select[i]) bus.m_readdata = pio_in[i];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic [2:0] a, input logic [31:0] d);
        bus.s_address    = a;
        bus.s_writedata  = d;
        bus.s_chipselect = 1'b1;
        bus.s_write_n    = 1'b0;
        @(negedge clk);
        bus.s_chipselect = 1'b0;
        bus.s_write_n    = 1'b1;
        bus.s_address    = 3'd0;
    endtask

    task automatic host_read(input logic [2:0] a, output logic [31:0] d);
        bus.s_address    = a;
        bus.s_chipselect = 1'b1;
        bus.s_read       = 1'b1;
        @(negedge clk);
        d                = bus.s_readdata;
        bus.s_chipselect = 1'b0;
        bus.s_read       = 1'b0;
        bus.s_address    = 3'd0;
    endtask

    // Returns at the negedge inside the first RD_ADDR cycle of a poll (sel 0 = any port).
    task automatic wait_poll(input logic [3:0] sel);
        logic prev, hit;
        hit  = 1'b0;
        prev = bus.m_chipselect;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (bus.m_chipselect && bus.m_write_n && !prev &&
                (sel == 4'd0 || bus.m_select == sel)) hit = 1'b1;
            prev = bus.m_chipselect;
        end
        chk("poll_seen", 32'(hit), 32'd1);
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.s_address    = 3'd0;
        bus.s_chipselect = 1'b0;
        bus.s_read       = 1'b0;
        bus.s_write_n    = 1'b1;
        bus.s_writedata  = '0;
        for (int i = 0; i < 4; i++) pio_in[i] = '0;
        drain_exp = '{32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h18, 32'h1A};
        repeat (3) @(negedge clk);
        chk("rst_readdata", bus.s_readdata, 32'd0);
        chk("rst_select", 32'(bus.m_select), 32'd0);
        chk("rst_address", 32'(bus.m_address), 32'd0);
        chk("rst_cs", 32'(bus.m_chipselect), 32'd0);
        chk("rst_write_n", 32'(bus.m_write_n), 32'd1);
        chk("rst_writedata", bus.m_writedata, 32'd0);
        chk("rst_irq", 32'(bus.irq), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Prime every port, then change port1 to 0x5
        host_write(3'd0, 32'h0004_0003);
        host_read(3'd0, rd);  chk("ctrl_rb", rd, 32'h0004_0003);
        host_read(3'd7, rd);  chk("reg7", rd, 32'd0);
        wait_poll(4'b0001);
        wait_poll(4'b0001);
        pio_in[1] = 32'h5;
        wait_poll(4'b0010);
        repeat (3) @(negedge clk);
        chk("irq_before", 32'(bus.irq), 32'd0);
        @(negedge clk);
        chk("irq_rise", 32'(bus.irq), 32'd1);
        host_read(3'd2, rd);  chk("evt_info", rd, 32'h8000_0001);
        host_read(3'd1, rd);  chk("status_cnt1", rd, 32'h0001_0000);
        host_read(3'd3, rd);  chk("evt_data", rd, 32'h5);
        chk("irq_hold", 32'(bus.irq), 32'd1);
        @(negedge clk);
        chk("irq_fall", 32'(bus.irq), 32'd0);
        host_read(3'd1, rd);  chk("status_cnt0", rd, 32'd0);
        host_read(3'd3, rd);  chk("pop_empty", rd, 32'd0);
        host_read(3'd2, rd);  chk("info_empty", rd, 32'd0);

        // Forwarded write queued during RD_WAIT, second one dropped
        host_write(3'd4, 32'd6);
        host_read(3'd4, rd);  chk("outsel_wrap", rd, 32'd2);
        wait_poll(4'd0);
        @(negedge clk);
        host_write(3'd5, 32'hA5);
        host_write(3'd5, 32'h5A);
        chk("wr_gap_cs", 32'(bus.m_chipselect), 32'd0);
        @(negedge clk);
        chk("wr_cs", 32'(bus.m_chipselect), 32'd1);
        chk("wr_write_n", 32'(bus.m_write_n), 32'd0);
        chk("wr_select", 32'(bus.m_select), 32'b0100);
        chk("wr_data", bus.m_writedata, 32'hA5);
        @(negedge clk);
        host_read(3'd1, rd);  chk("wr_drop", rd, 32'h2);
        host_write(3'd1, 32'h2);
        host_read(3'd1, rd);  chk("wr_drop_clr", rd, 32'd0);

        // Nine changes on port0 into an eight-entry FIFO
        for (int k = 1; k <= 9; k++) begin
            wait_poll(4'b0010);
            pio_in[0] = 32'h10 + 32'(k);
        end
        wait_poll(4'b0010);
        host_read(3'd1, rd);  chk("ovf_status", rd, 32'h0008_0001);
        chk("ovf_irq", 32'(bus.irq), 32'd1);
        host_write(3'd1, 32'h1);
        host_read(3'd1, rd);  chk("ovf_clr", rd, 32'h0008_0000);
        host_read(3'd2, rd);  chk("ovf_head", rd, 32'h8000_0000);

        // Pop lands on the same edge as a push into the full FIFO
        wait_poll(4'b0010);
        pio_in[0] = 32'h1A;
        wait_poll(4'b0001);
        repeat (2) @(negedge clk);
        host_read(3'd3, rd);  chk("simul_pop", rd, 32'h11);
        host_read(3'd1, rd);  chk("simul_status", rd, 32'h0008_0000);
        for (int i = 0; i < 8; i++) begin
            host_read(3'd3, rd);
            chk($sformatf("drain%0d", i), rd, drain_exp[i]);
        end
        host_read(3'd1, rd);  chk("drained", rd, 32'd0);

        // Interval 10 with four ports gives a 40-cycle revisit
        host_write(3'd0, 32'h000A_0003);
        repeat (30) @(negedge clk);
        wait_poll(4'b0100);
        pio_in[3] = 32'h31;
        wait_poll(4'b1000);
        ta = cyc;
        wait_poll(4'b0100);
        pio_in[3] = 32'h32;
        wait_poll(4'b1000);
        tb = cyc;
        chk("revisit", 32'(tb - ta), 32'd40);
        repeat (4) @(negedge clk);
        host_read(3'd6, t1);
        host_read(3'd3, rd);  chk("ts_evt0", rd, 32'h31);
        host_read(3'd6, t2);
        host_read(3'd3, rd);  chk("ts_evt1", rd, 32'h32);
`ifdef PIO_POLL_TIMESTAMP_EN
        chk("ts_delta", t2 - t1, 32'd40);
`else
        chk("ts_absent0", t1, 32'd0);
        chk("ts_absent1", t2, 32'd0);
`endif

        // Reset asserted during RD_WAIT with an event pending
        host_write(3'd0, 32'h0004_0003);
        wait_poll(4'b0010);
        pio_in[2] = 32'h7;
        wait_poll(4'b1000);
        wait_poll(4'b0001);
        @(negedge clk);
        chk("pre_rst_irq", 32'(bus.irq), 32'd1);
        chk("pre_rst_cs", 32'(bus.m_chipselect), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_cs", 32'(bus.m_chipselect), 32'd0);
        chk("async_select", 32'(bus.m_select), 32'd0);
        chk("async_write_n", 32'(bus.m_write_n), 32'd1);
        chk("async_writedata", bus.m_writedata, 32'd0);
        chk("async_readdata", bus.s_readdata, 32'd0);
        chk("async_irq", 32'(bus.irq), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        host_read(3'd0, rd);  chk("post_rst_ctrl", rd, 32'd0);
        host_read(3'd1, rd);  chk("post_rst_status", rd, 32'd0);
        host_write(3'd0, 32'h0004_0003);
        wait_poll(4'b0001);
        wait_poll(4'b0001);
        host_read(3'd1, rd);  chk("reprime_no_evt", rd, 32'd0);
        chk("reprime_irq", 32'(bus.irq), 32'd0);

        // Disabled: forwarded write issues one cycle after acceptance, priming resets
        host_write(3'd0, 32'd0);
        repeat (8) @(negedge clk);
        pio_in[1] = 32'h99;
        host_write(3'd4, 32'd1);
        host_write(3'd5, 32'h1234);
        chk("dis_wr_gap", 32'(bus.m_chipselect), 32'd0);
        @(negedge clk);
        chk("dis_wr_cs", 32'(bus.m_chipselect), 32'd1);
        chk("dis_wr_write_n", 32'(bus.m_write_n), 32'd0);
        chk("dis_wr_select", 32'(bus.m_select), 32'b0010);
        chk("dis_wr_data", bus.m_writedata, 32'h1234);
        host_write(3'd0, 32'h0004_0003);
        wait_poll(4'b0001);
        wait_poll(4'b0001);
        host_read(3'd1, rd);  chk("reenable_no_evt", rd, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
